// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and the write-back FIFO entry record for alu_wb.
package alu_pkg;
  localparam int DATA_W = 4;
  localparam int REG_N = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int REG_AW = $clog2(REG_N);
  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic zero;
    logic carry;
    logic sign;
    logic [REG_AW-1:0] dst;
    logic wen;
    logic fwen;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: 2-entry in-order result FIFO; storage and read pointer are exposed for head access and bypass.
module wb_fifo
  import alu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  wb_entry_t                   din,
  output wb_entry_t [FIFO_DEPTH-1:0]  mem,
  output logic                        rd_ptr,
  output logic                        full,
  output logic                        empty,
  output logic [1:0]                  count
);
  logic wr_ptr;
  logic do_push;
  logic do_pop;
  assign full = count == 2'(FIFO_DEPTH);
  assign empty = count == 2'd0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ do_push;
      rd_ptr <= rd_ptr ^ do_pop;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
  // Payload needs no reset: it is only observed while count marks it valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/alu_wb.sv
// alu_wb: ALU write-back stage with register file, flag register and 2-entry retire FIFO.
// Define ALU_WB_BYPASS_EN to forward pending FIFO results onto the read ports.
module alu_wb
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic              in_zero,
  input  logic              in_carry,
  input  logic              in_sign,
  input  logic [REG_AW-1:0] in_dst,
  input  logic              in_wen,
  input  logic              in_fwen,
  input  logic              ext_we,
  input  logic [REG_AW-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  input  logic [REG_AW-1:0] rd_a_addr,
  input  logic [REG_AW-1:0] rd_b_addr,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_sign,
  output logic [1:0]        pend_cnt
);
  wb_entry_t [FIFO_DEPTH-1:0] mem;
  wb_entry_t din;
  wb_entry_t head;
  logic rd_ptr;
  logic full;
  logic empty;
  logic push;
  logic retire;
  logic [DATA_W-1:0] rf [REG_N];
  assign din = '{r: in_r, zero: in_zero, carry: in_carry, sign: in_sign,
                 dst: in_dst, wen: in_wen, fwen: in_fwen};
  assign in_ready = !full;
  assign push = in_valid && in_ready;
  assign retire = !empty && !ext_we;
  assign head = mem[rd_ptr];
  wb_fifo u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(retire), .din(din),
    .mem(mem), .rd_ptr(rd_ptr), .full(full), .empty(empty), .count(pend_cnt)
  );
  // External loads block retire, so the two never write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else if (ext_we) begin
      rf[ext_addr] <= ext_data;
    end else if (retire && head.wen) begin
      rf[head.dst] <= head.r;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {flag_zero, flag_carry, flag_sign} <= 3'b000;
    else if (retire && head.fwen) {flag_zero, flag_carry, flag_sign} <= {head.zero, head.carry, head.sign};
  end
`ifdef ALU_WB_BYPASS_EN
  wb_entry_t young;
  assign young = mem[~rd_ptr];
  // Younger pending write to the same register shadows the older one.
  assign rd_a = (full && young.wen && young.dst == rd_a_addr) ? young.r :
                (!empty && head.wen && head.dst == rd_a_addr) ? head.r : rf[rd_a_addr];
  assign rd_b = (full && young.wen && young.dst == rd_b_addr) ? young.r :
                (!empty && head.wen && head.dst == rd_b_addr) ? head.r : rf[rd_b_addr];
`else
  assign rd_a = rf[rd_a_addr];
  assign rd_b = rf[rd_b_addr];
`endif
endmodule

// File: tb/tb_alu_wb.sv
// tb_alu_wb: directed and random checks of alu_wb against a queue-based write-back model.
module tb_alu_wb;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [3:0] in_r = '0;
  logic in_zero = 1'b0, in_carry = 1'b0, in_sign = 1'b0;
  logic [1:0] in_dst = '0;
  logic in_wen = 1'b0, in_fwen = 1'b0;
  logic ext_we = 1'b0;
  logic [1:0] ext_addr = '0;
  logic [3:0] ext_data = '0;
  logic [1:0] rd_a_addr = '0, rd_b_addr = '0;
  logic [3:0] rd_a, rd_b;
  logic flag_zero, flag_carry, flag_sign;
  logic [1:0] pend_cnt;
  int n_chk = 0;
  int n_err = 0;
  wb_entry_t q[$];
  logic [3:0] m_rf [4];
  logic [2:0] m_fl;
  wb_entry_t nil;

  alu_wb dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_r(in_r),
    .in_zero(in_zero), .in_carry(in_carry), .in_sign(in_sign), .in_dst(in_dst),
    .in_wen(in_wen), .in_fwen(in_fwen), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_data(ext_data), .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_a(rd_a),
    .rd_b(rd_b), .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_sign(flag_sign),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic wb_entry_t mk(input logic [3:0] r, input logic z, input logic c, input logic s,
                                   input logic [1:0] dst, input logic wen, input logic fwen);
    wb_entry_t e;
    e.r = r; e.zero = z; e.carry = c; e.sign = s; e.dst = dst; e.wen = wen; e.fwen = fwen;
    return e;
  endfunction

  function automatic logic [3:0] m_rd(input logic [1:0] a);
`ifdef ALU_WB_BYPASS_EN
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].wen && q[i].dst == a) return q[i].r;
`endif
    return m_rf[a];
  endfunction

  task automatic m_clear();
    q.delete();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_fl = '0;
  endtask

  // One clock: drive at the falling edge, check pre-edge state, advance the model, return at next falling edge.
  task automatic cyc(input logic v, input wb_entry_t e, input logic ewe, input logic [1:0] ea,
                     input logic [3:0] ed, input logic [1:0] ra, input logic [1:0] rb);
    bit rdy, ret;
    wb_entry_t h;
    in_valid = v; in_r = e.r; in_zero = e.zero; in_carry = e.carry; in_sign = e.sign;
    in_dst = e.dst; in_wen = e.wen; in_fwen = e.fwen;
    ext_we = ewe; ext_addr = ea; ext_data = ed; rd_a_addr = ra; rd_b_addr = rb;
    #1;
    rdy = q.size() != 2;
    ret = q.size() != 0 && !ewe;
    chk("ready", 8'(in_ready), 8'(rdy));
    chk("pend", 8'(pend_cnt), 8'(q.size()));
    chk("flags", 8'({flag_zero, flag_carry, flag_sign}), 8'(m_fl));
    chk("rd_a", 8'(rd_a), 8'(m_rd(ra)));
    chk("rd_b", 8'(rd_b), 8'(m_rd(rb)));
    if (ewe) m_rf[ea] = ed;
    else if (ret) begin
      h = q.pop_front();
      if (h.wen) m_rf[h.dst] = h.r;
      if (h.fwen) m_fl = {h.zero, h.carry, h.sign};
    end
    if (v && rdy) q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [1:0] ra);
    cyc(1'b0, nil, 1'b0, 2'd0, 4'd0, ra, 2'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pend"}, 8'(pend_cnt), 8'd0);
    chk({tag, "_ready"}, 8'(in_ready), 8'd1);
    chk({tag, "_flags"}, 8'({flag_zero, flag_carry, flag_sign}), 8'd0);
    for (int i = 0; i < 4; i++) begin
      rd_a_addr = 2'(i);
      #1;
      chk({tag, "_reg"}, 8'(rd_a), 8'd0);
    end
  endtask

  initial begin
    nil = '0;
    m_clear();
    @(negedge clk);
    @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, mk(4'hA, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1), 1'b0, 2'd0, 4'd0, 2'd2, 2'd0);
    chk("lat_pend1", 8'(pend_cnt), 8'd1);
    idle(2'd2);
    #1;
    chk("lat_r2", 8'(rd_a), 8'hA);
    chk("lat_flags", 8'({flag_zero, flag_carry, flag_sign}), 8'b011);
    chk("lat_pend0", 8'(pend_cnt), 8'd0);
    cyc(1'b1, mk(4'h4, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0), 1'b1, 2'd0, 4'h6, 2'd3, 2'd0);
    cyc(1'b1, mk(4'h9, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0), 1'b1, 2'd0, 4'h6, 2'd3, 2'd0);
    #1;
    chk("hold_ready", 8'(in_ready), 8'd0);
    chk("hold_pend", 8'(pend_cnt), 8'd2);
    cyc(1'b1, mk(4'hE, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0), 1'b1, 2'd0, 4'h6, 2'd3, 2'd0);
    chk("hold_pend3", 8'(pend_cnt), 8'd2);
    idle(2'd3);
    #1;
    chk("order_pend", 8'(pend_cnt), 8'd1);
`ifdef ALU_WB_BYPASS_EN
    chk("order_r3", 8'(rd_a), 8'h9);
`else
    chk("order_r3", 8'(rd_a), 8'h4);
`endif
    idle(2'd3);
    #1;
    chk("drain_r3", 8'(rd_a), 8'h9);
    chk("drain_r0", 8'(rd_b), 8'h6);
    cyc(1'b0, nil, 1'b1, 2'd1, 4'h3, 2'd1, 2'd0);
    cyc(1'b1, mk(4'h5, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0), 1'b0, 2'd0, 4'd0, 2'd1, 2'd0);
    idle(2'd1);
    #1;
    chk("ext_then_ret", 8'(rd_a), 8'h5);
    cyc(1'b1, mk(4'h5, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0), 1'b0, 2'd0, 4'd0, 2'd1, 2'd0);
    idle(2'd1);
    cyc(1'b0, nil, 1'b1, 2'd1, 4'h3, 2'd1, 2'd0);
    #1;
    chk("ret_then_ext", 8'(rd_a), 8'h3);
    cyc(1'b0, nil, 1'b1, 2'd0, 4'h2, 2'd0, 2'd0);
    cyc(1'b1, mk(4'h1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0), 1'b1, 2'd3, 4'h0, 2'd0, 2'd0);
    cyc(1'b1, mk(4'h7, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0), 1'b1, 2'd3, 4'h0, 2'd0, 2'd0);
    #1;
`ifdef ALU_WB_BYPASS_EN
    chk("bypass_r0", 8'(rd_a), 8'h7);
`else
    chk("bypass_r0", 8'(rd_a), 8'h2);
`endif
    idle(2'd0);
    idle(2'd0);
    #1;
    chk("bypass_drain", 8'(rd_a), 8'h7);
    cyc(1'b1, mk(4'h0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1), 1'b0, 2'd0, 4'd0, 2'd1, 2'd3);
    idle(2'd1);
    #1;
    chk("fonly_zero", 8'(flag_zero), 8'd1);
    chk("fonly_r1", 8'(rd_a), 8'h3);
    cyc(1'b1, mk(4'hF, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1), 1'b1, 2'd3, 4'hC, 2'd2, 2'd3);
    cyc(1'b1, mk(4'hB, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1), 1'b1, 2'd3, 4'hC, 2'd2, 2'd3);
    #1;
    chk("prerst_pend", 8'(pend_cnt), 8'd2);
    ext_we = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b0;
    m_clear();
    #1;
    reset_checks("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2'd2);
    idle(2'd1);
    #1;
    chk("postrst_r1", 8'(rd_a), 8'd0);
    chk("postrst_flags", 8'({flag_zero, flag_carry, flag_sign}), 8'd0);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), wb_entry_t'($urandom), $urandom_range(0, 3) == 0, 2'($urandom),
          4'($urandom), 2'($urandom), 2'($urandom));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
